// File: rtl/dmul_sched_pkg.sv
// Shared types and defaults for the two-requester stochastic multiplier scheduler.
package dmul_sched_pkg;

  localparam int DATAWD_DEF = 8;
  localparam int WINDOW_DEF = 255;
  localparam int CNTWD_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant; the pointer is owned by the parent.
module rr_arb2
  import dmul_sched_pkg::*;
(
  input  logic [1:0] i_valid,
  input  req_id_t    i_ptr,
  output logic       o_any,
  output req_id_t    o_gnt
);

  always_comb begin
    o_any = |i_valid;
    // With a single requester the grant simply follows it; the pointer only breaks ties.
    if (&i_valid) begin
      o_gnt = i_ptr;
    end else begin
      o_gnt = i_valid[1];
    end
  end

endmodule

// File: rtl/dmul_sched_rr.sv
// Round-robin scheduler sharing one unipolar stochastic multiplier between two requesters.
// Defining DMUL_SCHED_PERF_EN adds per-requester completed-job counters job_cnt0/job_cnt1.
module dmul_sched_rr
  import dmul_sched_pkg::*;
#(
  parameter int DATAWD = DATAWD_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNTWD  = CNTWD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATAWD-1:0]   req0_a,
  input  logic [DATAWD-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATAWD-1:0]   req1_a,
  input  logic [DATAWD-1:0]   req1_b,
  output logic [DATAWD-1:0]   mul_iA,
  output logic [DATAWD-1:0]   mul_iB,
  output logic                mul_loadA,
  output logic                mul_loadB,
  input  logic [2*DATAWD-1:0] mul_oC,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic [2*DATAWD-1:0] resp_data,
  output logic                busy
`ifdef DMUL_SCHED_PERF_EN
  ,
  output logic [15:0]         job_cnt0,
  output logic [15:0]         job_cnt1
`endif
);

  localparam logic [CNTWD-1:0] LP_LAST = CNTWD'(WINDOW - 1);

  state_t              r_state;
  req_id_t             r_rr_ptr;
  req_id_t             r_id_q;
  req_id_t             r_resp_id;
  logic [DATAWD-1:0]   r_op_a;
  logic [DATAWD-1:0]   r_op_b;
  logic [CNTWD-1:0]    r_cnt;
  logic [2*DATAWD-1:0] r_resp_data;

  logic    w_any;
  req_id_t w_gnt;
  logic    w_idle;
  logic    w_resp_hs;

  rr_arb2 u_arb (
    .i_valid ({req1_valid, req0_valid}),
    .i_ptr   (r_rr_ptr),
    .o_any   (w_any),
    .o_gnt   (w_gnt)
  );

  assign w_idle     = (r_state == IDLE) && !rst;
  assign w_resp_hs  = (r_state == RESP) && resp_ready;
  assign req0_ready = w_idle && w_any && (w_gnt == 1'b0);
  assign req1_ready = w_idle && w_any && (w_gnt == 1'b1);

  // Operand registers double as the multiplier inputs, so they hold the last issued job.
  assign mul_iA     = r_op_a;
  assign mul_iB     = r_op_b;
  assign mul_loadA  = (r_state == LOAD);
  assign mul_loadB  = (r_state == LOAD);
  assign resp_valid = (r_state == RESP);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_id_q      <= 1'b0;
      r_resp_id   <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_cnt       <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a  <= w_gnt ? req1_a : req0_a;
            r_op_b  <= w_gnt ? req1_b : req0_b;
            r_id_q  <= w_gnt;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (r_cnt == LP_LAST) begin
            r_state <= CAPT;
          end else begin
            r_cnt <= r_cnt + CNTWD'(1);
          end
        end
        CAPT: begin
          // The count seen here already holds exactly WINDOW accumulations.
          r_resp_data <= mul_oC;
          r_resp_id   <= r_id_q;
          r_rr_ptr    <= ~r_id_q;
          r_state     <= RESP;
        end
        RESP: begin
          if (w_resp_hs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DMUL_SCHED_PERF_EN
  logic [15:0] r_job_cnt0;
  logic [15:0] r_job_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_job_cnt0 <= '0;
      r_job_cnt1 <= '0;
    end else if (w_resp_hs) begin
      if (r_resp_id) begin
        r_job_cnt1 <= r_job_cnt1 + 16'd1;
      end else begin
        r_job_cnt0 <= r_job_cnt0 + 16'd1;
      end
    end
  end

  assign job_cnt0 = r_job_cnt0;
  assign job_cnt1 = r_job_cnt1;
`endif

endmodule

// File: tb/tb_dmul_sched_rr.sv
// Self-checking bench for dmul_sched_rr: cycle-timed job model, stub and LFSR multiplier models.
module tb_dmul_sched_rr;

  localparam int W = 255;
  localparam logic [7:0] SEEDA = 8'h01;
  localparam logic [7:0] SEEDB = 8'hA5;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [7:0]  mul_iA, mul_iB;
  logic        mul_loadA, mul_loadB;
  logic [15:0] mul_oC;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] resp_data;
  logic        busy;
`ifdef DMUL_SCHED_PERF_EN
  logic [15:0] job_cnt0, job_cnt1;
`endif

  dmul_sched_rr dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .mul_iA     (mul_iA),
    .mul_iB     (mul_iB),
    .mul_loadA  (mul_loadA),
    .mul_loadB  (mul_loadB),
    .mul_oC     (mul_oC),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
`ifdef DMUL_SCHED_PERF_EN
    ,
    .job_cnt0   (job_cnt0),
    .job_cnt1   (job_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Reference count: number of stream positions where both compares fire over one window.
  function automatic logic [15:0] ref_count(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] la, lb;
    int c;
    la = SEEDA; lb = SEEDB; c = 0;
    for (int k = 0; k < W; k++) begin
      if ((la < a) && (lb < b)) c++;
      la = lfsr_next(la);
      lb = lfsr_next(lb);
    end
    return 16'(c);
  endfunction

  // Multiplier models: stub counter or LFSR-based stochastic multiplier.
  bit          real_mode = 1'b0;
  logic [15:0] stub_cnt  = '0;
  logic [15:0] real_cnt  = '0;
  logic [7:0]  lfa = SEEDA, lfb = SEEDB, ra = '0, rb = '0;

  always @(posedge clk) begin
    if (mul_loadA) begin
      stub_cnt <= '0;
      real_cnt <= '0;
      lfa      <= SEEDA;
      lfb      <= SEEDB;
      ra       <= mul_iA;
      rb       <= mul_iB;
    end else begin
      stub_cnt <= stub_cnt + 16'd1;
      real_cnt <= real_cnt + (((lfa < ra) && (lfb < rb)) ? 16'd1 : 16'd0);
      lfa      <= lfsr_next(lfa);
      lfb      <= lfsr_next(lfb);
    end
  end

  assign mul_oC = real_mode ? real_cnt : stub_cnt;

  // Behavioural model: m_t counts clock edges since the acceptance edge of the active job.
  bit          chk_en = 1'b0;
  bit          m_active, m_id, m_ptr, m_resp_id;
  int          m_t;
  logic [7:0]  m_ia, m_ib;
  logic [15:0] m_exp_data, m_resp_data;
  logic [15:0] m_cnt0, m_cnt1;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 0; m_t = 0; m_ptr = 0; m_id = 0;
        m_ia = '0; m_ib = '0; m_resp_data = '0; m_resp_id = 0;
        m_cnt0 = '0; m_cnt1 = '0;
        chk_en = 1'b1;
      end else if (!m_active) begin
        if (req0_valid || req1_valid) begin
          m_id       = (req0_valid && req1_valid) ? m_ptr : req1_valid;
          m_ia       = m_id ? req1_a : req0_a;
          m_ib       = m_id ? req1_b : req0_b;
          m_exp_data = real_mode ? ref_count(m_ia, m_ib) : 16'(W);
          m_active   = 1;
          m_t        = 0;
        end
      end else if (m_t >= W + 2) begin
        if (resp_ready) begin
          m_active = 0;
          if (m_id) m_cnt1 = m_cnt1 + 16'd1;
          else      m_cnt0 = m_cnt0 + 16'd1;
        end
      end else begin
        m_t++;
        if (m_t == W + 2) begin
          m_resp_data = m_exp_data;
          m_resp_id   = m_id;
          m_ptr       = !m_id;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [38:0] act, exp;
    logic e_any, e_gnt;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_any = !rst && !m_active && (req0_valid || req1_valid);
        e_gnt = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        act = {busy, resp_valid, resp_id, resp_data, mul_loadA, mul_loadB,
               mul_iA, mul_iB, req0_ready, req1_ready};
        exp = {m_active, m_active && (m_t >= W + 2), m_resp_id, m_resp_data,
               m_active && (m_t == 0), m_active && (m_t == 0),
               m_ia, m_ib, e_any && !e_gnt, e_any && e_gnt};
        chk("outputs", 64'(act), 64'(exp));
`ifdef DMUL_SCHED_PERF_EN
        chk("job_cnt", 64'({job_cnt0, job_cnt1}), 64'({m_cnt0, m_cnt1}));
`endif
      end
    end
  end

  // Event monitor for the directed checks.
  int         load_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0;
  logic [7:0] last_ia = '0, last_ib = '0;
  bit         ids[$];

  initial begin
    forever begin
      @(negedge clk);
      if (mul_loadA) begin
        load_cnt++;
        last_ia = mul_iA;
        last_ib = mul_iB;
      end
      if (req0_ready) rdy0_cnt++;
      if (req1_ready) rdy1_cnt++;
      if (resp_valid && resp_ready) ids.push_back(resp_id);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!resp_valid && lat < 400) begin
      tick();
      lat++;
    end
    chk("resp_valid_seen", 64'(resp_valid), 64'd1);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 600) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_job(input bit id, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [15:0] data, output bit rid);
    resp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    chk("job_grant", 64'(id ? req1_ready : req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_valid(lat);
    data = resp_data;
    rid  = resp_id;
    tick();
  endtask

  initial begin
    int          lat;
    logic [15:0] d, d0;
    bit          rid, id0;
    bit          exp_ids[4];
    int          n;

    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp", 64'({resp_valid, resp_id, resp_data}), 64'd0);
    chk("rst_mul", 64'({mul_loadA, mul_loadB, mul_iA, mul_iB}), 64'd0);

    // Timing with the stub multiplier
    load_cnt = 0;
    run_job(1'b0, 8'h40, 8'h80, lat, d, rid);
    chk("t1_latency", 64'(lat), 64'd257);
    chk("t1_data", 64'(d), 64'd255);
    chk("t1_id", 64'(rid), 64'd0);
    chk("t1_loads", 64'(load_cnt), 64'd1);
    chk("t1_ops", 64'({last_ia, last_ib}), 64'h4080);

    // Arbitration: both valid continuously from a fresh pointer
    pulse_rst();
    ids.delete();
    rdy0_cnt = 0; rdy1_cnt = 0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (ids.size() < 4 && n < 1200) begin
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      tick();
      n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
    chk("arb_count", 64'(ids.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb_id%0d", i), 64'((i < ids.size()) ? ids[i] : !exp_ids[i]), 64'(exp_ids[i]));
    end
    chk("arb_rdy0_pulses", 64'(rdy0_cnt), 64'd2);
    chk("arb_rdy1_pulses", 64'(rdy1_cnt), 64'd2);

    // Backpressure with req1 waiting throughout
    tick();
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
    req1_valid = 1'b1; req1_a = 8'h56; req1_b = 8'h78;
    #1;
    chk("bp_grant0", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    wait_valid(lat);
    d0 = resp_data; id0 = resp_id;
    chk("bp_id", 64'(id0), 64'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold", 64'({resp_valid, resp_id, resp_data, req1_ready, busy}),
          64'({1'b1, id0, d0, 1'b0, 1'b1}));
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_regrant", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    wait_valid(lat);
    chk("bp_job1_id", 64'(resp_id), 64'd1);
    tick();

    // Real stochastic multiplier
    wait_idle();
    real_mode = 1'b1;
    run_job(1'b0, 8'h00, 8'hFF, lat, d, rid);
    chk("real_zero", 64'(d), 64'd0);
    run_job(1'b1, 8'hFF, 8'hFF, lat, d, rid);
    chk("real_full", 64'(d), 64'(ref_count(8'hFF, 8'hFF)));
    real_mode = 1'b0;

    // Reset at RUN cycle 100
    req1_valid = 1'b1; req1_a = 8'h99; req1_b = 8'h11;
    tick();
    req1_valid = 1'b0;
    tick();
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 64'(resp_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    run_job(1'b0, 8'h40, 8'h80, lat, d, rid);
    chk("rst_next_data", 64'(d), 64'd255);
    chk("rst_next_lat", 64'(lat), 64'd257);

    // Randomised traffic against the model
    real_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      req0_valid = ($urandom_range(0, 3) == 0);
      req1_valid = ($urandom_range(0, 3) == 0);
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      resp_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    wait_idle();
    real_mode = 1'b0;

    // Job counting: three from req0, two from req1
    pulse_rst();
    for (int j = 0; j < 5; j++) begin
      run_job((j >= 3), 8'($urandom), 8'($urandom), lat, d, rid);
      chk("perf_job_id", 64'(rid), 64'(j >= 3));
    end
`ifdef DMUL_SCHED_PERF_EN
    tick();
    chk("perf_cnt0", 64'(job_cnt0), 64'd3);
    chk("perf_cnt1", 64'(job_cnt1), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmul_sched_rr.md
Name: dmul_sched_rr

Overview:
- Two-requester scheduler that shares one unipolar stochastic multiplier (8-bit operands, 16-bit accumulated count output) between clients.
- Accepts jobs over valid/ready and arbitrates round-robin.
- Drives the multiplier's operand load strobes, times the bitstream window and captures the accumulated count.
- Returns the result tagged with the requester ID. Sits between the compute clients and the multiplier instance.

Parameters:
- DATAWD, 8, operand width; the result is 2*DATAWD bits.
- WINDOW, 255, bitstream length in cycles (LFSR period 2^DATAWD-1); legal range 1..2^(2*DATAWD)-1.
- CNTWD, 16, width of the window counter; must satisfy 2^CNTWD > WINDOW.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 job valid
- req0_ready  out  1  requester 0 job accepted this cycle
- req0_a  in  DATAWD  requester 0 operand A
- req0_b  in  DATAWD  requester 0 operand B
- req1_valid  in  1  requester 1 job valid
- req1_ready  out  1  requester 1 job accepted this cycle
- req1_a  in  DATAWD  requester 1 operand A
- req1_b  in  DATAWD  requester 1 operand B
- mul_iA  out  DATAWD  operand A to multiplier
- mul_iB  out  DATAWD  operand B to multiplier
- mul_loadA  out  1  multiplier load A; also clears the multiplier count
- mul_loadB  out  1  multiplier load B
- mul_oC  in  2*DATAWD  multiplier accumulated count
- resp_valid  out  1  result valid
- resp_ready  in  1  result accepted
- resp_id  out  1  requester that owns the result
- resp_data  out  2*DATAWD  captured count
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous, active-high; one clock, clk.
- Reset values:
  - state=IDLE, rr_ptr=0 (requester 0 has priority first).
  - All outputs 0: req*_ready, mul_load*, mul_i*, resp_valid, resp_id, resp_data, busy.
- FSM states: IDLE, LOAD, RUN, CAPT, RESP.
- IDLE:
  - If any reqN_valid, grant one requester: if both are valid, grant rr_ptr; otherwise grant the one that is valid.
  - reqN_ready is combinational, high only for the granted requester, only in IDLE.
  - On grant, latch operands into op_a/op_b and the ID into id_q; go to LOAD.
- LOAD (1 cycle):
  - mul_loadA=mul_loadB=1, mul_iA=op_a, mul_iB=op_b.
  - The multiplier clears its count at this edge.
  - Clear the window counter; go to RUN.
- RUN:
  - The multiplier accumulates one compare per cycle.
  - The counter increments every cycle; on the cycle where counter==WINDOW-1, go to CAPT.
  - RUN therefore lasts exactly WINDOW cycles.
- CAPT (1 cycle):
  - resp_data <= mul_oC, sampled in this cycle; this value includes exactly WINDOW accumulations.
  - resp_id <= id_q; rr_ptr <= ~id_q; go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_id are held stable.
  - On resp_valid & resp_ready, go to IDLE; no new grant is made in the same cycle.
  - The multiplier keeps counting freely; its count is don't-care outside RUN/CAPT.
- mul_loadA/B are high only in LOAD. mul_iA/B hold the last issued operands at all other times.
- Job latency, grant to resp_valid: 1 (LOAD) + WINDOW (RUN) + 1 (CAPT) = WINDOW+2 cycles after the acceptance edge.
- Minimum job-to-job interval: WINDOW+4 cycles.
- Boundary conditions:
  - Both requesters valid continuously: grants alternate 0,1,0,1.
  - A requester that drops valid before being granted is not served (no latching of ungranted requests).
  - WINDOW=1: RUN lasts 1 cycle.
  - resp_ready held low: the FSM stalls in RESP indefinitely and req*_ready stays 0.
  - rst asserted in any state: back to IDLE, resp_valid drops the next edge, and the in-flight job is discarded with no response.
  - mul_oC is not checked for overflow; a count of WINDOW fits in 2*DATAWD bits by parameter rule.

Optional Feature:
- Macro: DMUL_SCHED_PERF_EN.
- Defined:
  - Adds output ports job_cnt0 and job_cnt1, each 16 bits.
  - Each counter increments on a completed response handshake for its ID, wraps at 0xFFFF->0 and is reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmul_sched_pkg holds:
  - The state enum (IDLE, LOAD, RUN, CAPT, RESP).
  - DATAWD default and the WINDOW default localparam.
  - The requester ID typedef (1 bit).
- Sub-module rr_arb2: 2-input round-robin arbiter, combinational grant from valid[1:0] and a pointer. The pointer update stays in the parent.

Test Plan:
- Timing check:
  - Stimulus: stub multiplier whose mul_oC increments every cycle after loadA; WINDOW=255; req0 A=0x40, B=0x80.
  - Required: mul_loadA/B pulse once with iA=0x40, iB=0x80; resp_valid rises 257 cycles after acceptance; resp_data=255; resp_id=0.
- Arbitration:
  - Stimulus: req0 and req1 both valid continuously for 4 jobs, resp_ready=1.
  - Required: resp_id sequence 0,1,0,1; each req*_ready is a single-cycle pulse per job.
- Backpressure:
  - Stimulus: resp_ready=0 for 20 cycles after resp_valid, with req1 valid throughout.
  - Required: resp_data/resp_id stable, req1_ready=0, busy=1; after the resp_ready handshake, req1 is granted 1 cycle later.
- Real multiplier:
  - Stimulus: real multiplier attached, A=0, B=0xFF.
  - Required: resp_data=0.
  - Stimulus: A=0xFF, B=0xFF.
  - Required: resp_data equals the reference-model count from the LFSR sequences.
- Reset mid-job:
  - Stimulus: rst=1 for 1 cycle at RUN cycle 100.
  - Required: next cycle state=IDLE, resp_valid=0, busy=0; the next job completes normally with resp_data=255 (stub).
- Performance counters (DMUL_SCHED_PERF_EN defined):
  - Stimulus: 3 jobs from req0 and 2 from req1.
  - Required: job_cnt0=3, job_cnt1=2.
